riscv_regfile_mp: RTL and testbench

Parametrised multi-port register file. It is the successor to the single-cycle datapath register file.
- Configurable data width, register count and number of read/write ports.
- Optional hardwired-zero register 0.
- Selectable read mode: combinational for the single-cycle core, or registered with a stall enable for multi-cycle/pipelined cores.
- Includes write-to-read bypass.
- Sits inside the datapath, between decode and the ALU/writeback muxes.

---
 rtl/riscv_regfile_mp_pkg.sv | 12 +
 rtl/riscv_regfile_rdmux.sv | 44 ++++
 rtl/riscv_regfile_mp.sv | 69 ++++++
 tb/tb_riscv_regfile_mp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: read-mode encodings
// and a small helper used when deciding whether a register index is hardwired.
package riscv_regfile_mp_pkg;

  localparam int RF_READ_COMB = 0;
  localparam int RF_READ_REG  = 1;

  function automatic logic is_zero_idx(input int unsigned zero_reg, input logic [31:0] idx);
    return (zero_reg != 0) && (idx == 32'd0);
  endfunction

endpackage

// File: rtl/riscv_regfile_rdmux.sv
// Per-read-port selector: stored value, optionally overridden by a same-cycle
// write (highest write port wins), then forced to 0 for a hardwired x0.
module riscv_regfile_rdmux
  import riscv_regfile_mp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]        raddr,
  input  logic [WIDTH-1:0]     stored,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]     data
);

  logic             byp_hit;
  logic [WIDTH-1:0] byp_val;
  logic [31:0]      raddr_ext;

  assign raddr_ext = 32'(raddr);

  // Later ports overwrite earlier matches, giving the highest index priority.
  always_comb begin
    byp_hit = 1'b0;
    byp_val = '0;
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && (waddr[i*AW +: AW] == raddr)) begin
        byp_hit = 1'b1;
        byp_val = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data = stored;
    if ((BYPASS != 0) && byp_hit) data = byp_val;
    if (is_zero_idx(ZERO_REG, raddr_ext)) data = '0;
  end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Parametrised multi-port register file with optional hardwired x0,
// write-to-read bypass and either combinational or registered (stallable) reads.
module riscv_regfile_mp
  import riscv_regfile_mp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NREGS     = 32,
  parameter int AW        = $clog2(NREGS),
  parameter int NRD       = 2,
  parameter int NWR       = 1,
  parameter int READ_MODE = RF_READ_COMB,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic                 rd_en,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0]     regs [NREGS];
  logic [NRD*WIDTH-1:0] rd_next;

  // Ports are applied in index order so the higher port wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && !is_zero_idx(ZERO_REG, 32'(waddr[i*AW +: AW])))
          regs[waddr[i*AW +: AW]] <= wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    riscv_regfile_rdmux #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rdmux (
      .raddr  (raddr[j*AW +: AW]),
      .stored (regs[raddr[j*AW +: AW]]),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .data   (rd_next[j*WIDTH +: WIDTH])
    );
  end

  if (READ_MODE == RF_READ_REG) begin : g_rd_reg
    // rd_en low is a pipeline stall: the captured operands are held.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        rdata <= '0;
      else if (rd_en) rdata <= rd_next;
    end
  end else begin : g_rd_comb
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    assign rdata = rd_next;
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: four parameterisations driven side by side,
// checked against constant vectors and an array-based reference model.
module tb_riscv_regfile_mp;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  wire  [63:0] rd0, rd1, rd2;

  logic        we3;
  logic [2:0]  waddr3;
  logic [15:0] wdata3;
  logic [11:0] raddr3;
  wire  [63:0] rd3;

  int nchecks = 0;
  int nerrors = 0;

  // reference state
  logic [31:0] mem  [32];
  logic [15:0] mem3 [8];
  logic [31:0] rdq  [2];

  // d0: comb + bypass, d1: registered + bypass, d2: comb no bypass, d3: small/4-port/no x0
  riscv_regfile_mp #(.NWR(2)) d0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .raddr(raddr), .rdata(rd0));
  riscv_regfile_mp #(.NWR(2), .READ_MODE(1)) d1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .raddr(raddr), .rdata(rd1));
  riscv_regfile_mp #(.NWR(2), .BYPASS(0)) d2 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .raddr(raddr), .rdata(rd2));
  riscv_regfile_mp #(.WIDTH(16), .NREGS(8), .NRD(4), .ZERO_REG(0)) d3 (
    .clk(clk), .rst(rst), .we(we3), .waddr(waddr3), .wdata(wdata3),
    .rd_en(rd_en), .raddr(raddr3), .rdata(rd3[63:0]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_comb(input int j, input bit byp);
    logic [4:0]  a;
    logic [31:0] v;
    a = raddr[j*5 +: 5];
    if (a == 5'd0) return 32'd0;
    v = mem[a];
    if (byp) begin
      if (we[0] && waddr[4:0] == a) v = wdata[31:0];
      if (we[1] && waddr[9:5] == a) v = wdata[63:32];
    end
    return v;
  endfunction

  function automatic logic [15:0] exp3(input int j);
    logic [2:0] a;
    a = raddr3[j*3 +: 3];
    if (we3 && waddr3 == a) return wdata3;
    return mem3[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mem[r] = '0;
    for (int r = 0; r < 8; r++) mem3[r] = '0;
    rdq[0] = '0;
    rdq[1] = '0;
  endtask

  // One clock: pre-edge combinational checks, model update at the edge, registered checks after.
  task automatic step();
    #1;
    if (!rst) begin
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("d0_comb_rd%0d", j), 64'(rd0[j*32 +: 32]), 64'(exp_comb(j, 1'b1)));
        chk($sformatf("d2_nobyp_rd%0d", j), 64'(rd2[j*32 +: 32]), 64'(exp_comb(j, 1'b0)));
      end
      for (int j = 0; j < 4; j++)
        chk($sformatf("d3_rd%0d", j), 64'(rd3[j*16 +: 16]), 64'(exp3(j)));
    end
    @(posedge clk);
    if (!rst) begin
      if (rd_en) begin
        rdq[0] = exp_comb(0, 1'b1);
        rdq[1] = exp_comb(1, 1'b1);
      end
      if (we[0] && waddr[4:0] != 5'd0) mem[waddr[4:0]] = wdata[31:0];
      if (we[1] && waddr[9:5] != 5'd0) mem[waddr[9:5]] = wdata[63:32];
      if (we3) mem3[waddr3] = wdata3;
    end
    #1;
    for (int j = 0; j < 2; j++)
      chk($sformatf("d1_reg_rd%0d", j), 64'(rd1[j*32 +: 32]), 64'(rdq[j]));
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{2'b01, 5'd5,  32'h01,       5'd0, 32'h0,    5'd5,  5'd0, 32'h01,       32'h0};
    vecs[1]  = '{2'b01, 5'd6,  32'hfe,       5'd0, 32'h0,    5'd6,  5'd5, 32'hfe,       32'h01};
    vecs[2]  = '{2'b01, 5'd4,  32'h01,       5'd0, 32'h0,    5'd5,  5'd0, 32'h01,       32'h0};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd4,  5'd6, 32'h01,       32'hfe};
    vecs[4]  = '{2'b01, 5'd4,  32'hff,       5'd0, 32'h0,    5'd0,  5'd6, 32'h0,        32'hfe};
    vecs[5]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd4,  5'd4, 32'hff,       32'hff};
    vecs[6]  = '{2'b01, 5'd0,  32'h123,      5'd0, 32'h0,    5'd0,  5'd4, 32'h0,        32'hff};
    vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd0,  5'd0, 32'h0,        32'h0};
    vecs[8]  = '{2'b11, 5'd3,  32'haa,       5'd3, 32'hbb,   5'd3,  5'd3, 32'hbb,       32'hbb};
    vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd3,  5'd9, 32'hbb,       32'h0};
    vecs[10] = '{2'b01, 5'd9,  32'h55,       5'd0, 32'h0,    5'd9,  5'd9, 32'h55,       32'h55};
    vecs[11] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd9,  5'd3, 32'h55,       32'hbb};
    vecs[12] = '{2'b11, 5'd31, 32'hcafef00d, 5'd1, 32'h1234, 5'd31, 5'd1, 32'hcafef00d, 32'h1234};
    vecs[13] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,    5'd1,  5'd31, 32'h1234,    32'hcafef00d};

    rst = 1'b1; rd_en = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = {5'd0, 5'd5};
    we3 = 1'b0; waddr3 = '0; wdata3 = '0; raddr3 = '0;
    model_reset();

    // reset state, and writes blocked while reset is held
    #2;
    chk("reset_d0_rd0", 64'(rd0[31:0]), 64'h0);
    chk("reset_d1", 64'(rd1), 64'h0);
    chk("reset_d3", rd3, 64'h0);
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'habc};
    we3 = 1'b1; waddr3 = 3'd2; wdata3 = 16'h77;
    step();
    rst = 1'b0; we = '0; we3 = 1'b0; raddr3 = {3'd2, 3'd2, 3'd2, 3'd2};
    #1;
    chk("write_in_reset_d0", 64'(rd0[31:0]), 64'h0);
    chk("write_in_reset_d3", 64'(rd3[15:0]), 64'h0);

    // constant vectors on the combinational/bypass instance
    for (int k = 0; k < 14; k++) begin
      we = vecs[k].we;
      waddr = {vecs[k].wa1, vecs[k].wa0};
      wdata = {vecs[k].wd1, vecs[k].wd0};
      raddr = {vecs[k].ra1, vecs[k].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", k), 64'(rd0[31:0]), 64'(vecs[k].e0));
      chk($sformatf("vec%0d_rd1", k), 64'(rd0[63:32]), 64'(vecs[k].e1));
      step();
    end

    // no bypass: same-cycle write only visible after the edge
    we = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h77}; raddr = {5'd10, 5'd10};
    #1;
    chk("nobyp_before_edge", 64'(rd2[31:0]), 64'h0);
    chk("byp_before_edge", 64'(rd0[31:0]), 64'h77);
    step();
    we = '0;
    #1;
    chk("nobyp_after_edge", 64'(rd2[31:0]), 64'h77);

    // asynchronous reset pulsed between edges
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hdeadbeef}; raddr = {5'd0, 5'd7};
    step();
    we = '0;
    step();
    chk("pre_rst_d1", 64'(rd1[31:0]), 64'hdeadbeef);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_d0_x7", 64'(rd0[31:0]), 64'h0);
    chk("async_rst_d1", 64'(rd1), 64'h0);
    #1 rst = 1'b0;
    we = 2'b01; waddr = {5'd0, 5'd8}; wdata = {32'h0, 32'h11};
    step();
    we = '0; raddr = {5'd0, 5'd8};
    #1;
    chk("first_write_after_rst", 64'(rd2[31:0]), 64'h11);

    // registered read latency and stall
    we = 2'b11; waddr = {5'd6, 5'd5}; wdata = {32'h606, 32'h505};
    step();
    we = '0; rd_en = 1'b1; raddr = {5'd0, 5'd5};
    step();
    chk("regread_x5", 64'(rd1[31:0]), 64'h505);
    rd_en = 1'b0; raddr = {5'd0, 5'd6};
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall_%0d", c), 64'(rd1[31:0]), 64'h505);
    end
    rd_en = 1'b1;
    step();
    chk("regread_x6", 64'(rd1[31:0]), 64'h606);

    // small config without hardwired zero
    we3 = 1'b1; waddr3 = 3'd0; wdata3 = 16'hffff; raddr3 = '0;
    step();
    we3 = 1'b1; waddr3 = 3'd7; wdata3 = 16'h8001; raddr3 = {3'd0, 3'd7, 3'd7, 3'd0};
    step();
    we3 = 1'b0;
    #1;
    chk("d3_p0", 64'(rd3[15:0]),  64'hffff);
    chk("d3_p1", 64'(rd3[31:16]), 64'h8001);
    chk("d3_p2", 64'(rd3[47:32]), 64'h8001);
    chk("d3_p3", 64'(rd3[63:48]), 64'hffff);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      we = 2'($urandom_range(0, 3));
      waddr = 10'($urandom);
      wdata = {32'($urandom), 32'($urandom)};
      rd_en = ($urandom_range(0, 3) != 0);
      raddr[4:0] = ($urandom_range(0, 2) == 0) ? waddr[4:0] : 5'($urandom);
      raddr[9:5] = ($urandom_range(0, 2) == 0) ? waddr[9:5] : 5'($urandom);
      we3 = 1'($urandom);
      waddr3 = 3'($urandom);
      wdata3 = 16'($urandom);
      raddr3 = 12'($urandom);
      if ($urandom_range(0, 2) == 0) raddr3[2:0] = waddr3;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
